revolver_game_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 33 +++
 rtl/game_lfsr.sv | 23 ++
 rtl/revolver_game_ctrl.sv | 154 +++++++++++++++
 tb/tb_revolver_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the revolver game: colour-mapper scene codes,
// the sequencer state set and the cylinder LFSR seed.
package game_pkg;

    localparam logic [3:0] SCENE_MENU    = 4'hF;
    localparam logic [3:0] SCENE_IDLE    = 4'h0;
    localparam logic [3:0] SCENE_P1_TURN = 4'h2;
    localparam logic [3:0] SCENE_P2_TURN = 4'h1;
    localparam logic [3:0] SCENE_P1_DOWN = 4'h4;
    localparam logic [3:0] SCENE_P2_DOWN = 4'h5;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_IDLE,
        ST_P1_TURN,
        ST_P2_TURN,
        ST_FIRE,
        ST_RECOIL,
        ST_P1_DOWN,
        ST_P2_DOWN
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fold a 3-bit random draw onto the cylinder.
    function automatic logic [2:0] draw_chamber(input logic [2:0] r, input int chambers);
        int v;
        v = int'(r);
        if (v >= chambers) v = v - chambers;
        return v[2:0];
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to place
// the live round in the cylinder.
module game_lfsr
    import game_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= {feedback, lfsr_q[15:1]};
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/revolver_game_ctrl.sv
// Two-player revolver game sequencer driving color_mapper's scene, gun sprite
// and cylinder outputs. Define TURN_TIMEOUT_EN to auto-fire idle turns.
module revolver_game_ctrl
    import game_pkg::*;
#(
    parameter int CHAMBERS       = 6,
    parameter int IDLE_FRAMES    = 120,
    parameter int RECOIL_FRAMES  = 8,
    parameter int RECOIL_PX      = 6,
    parameter int DOWN_FRAMES    = 180,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       trigger_p1,
    input  logic       trigger_p2,
    output logic [3:0] cur_game_state,
    output logic       show_gun,
    output logic [9:0] gun_y_dis,
    output logic [2:0] chamber_idx,
    output logic [3:0] shots_fired
);

    localparam int MAX_A      = (IDLE_FRAMES > DOWN_FRAMES) ? IDLE_FRAMES : DOWN_FRAMES;
    localparam int MAX_B      = (RECOIL_FRAMES > TIMEOUT_FRAMES) ? RECOIL_FRAMES : TIMEOUT_FRAMES;
    localparam int MAX_FRAMES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    logic [15:0]      lfsr;
    logic             unused_lfsr_hi;
    logic [2:0]       level, prev_q, rise_q;
    state_e           state_q, state_d;
    logic             shooter_q, shooter_d;
    logic [2:0]       live_q, live_d, chamber_q, chamber_d;
    logic [3:0]       shots_q, shots_d, scene_q, scene_d;
    logic             show_q, show_d;
    logic [9:0]       gun_y_q, gun_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idle_done, recoil_done, down_done, timeout;

    game_lfsr u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .lfsr_o  (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:3];

    // Bit 0 start, bit 1 trigger_p1, bit 2 trigger_p2; rise pulses are registered.
    assign level = {trigger_p2, trigger_p1, start};

    assign idle_done   = frame_tick && (cnt_q == CNT_W'(IDLE_FRAMES - 1));
    assign recoil_done = frame_tick && (cnt_q == CNT_W'(RECOIL_FRAMES - 1));
    assign down_done   = frame_tick && (cnt_q == CNT_W'(DOWN_FRAMES - 1));
`ifdef TURN_TIMEOUT_EN
    assign timeout     = frame_tick && (cnt_q == CNT_W'(TIMEOUT_FRAMES - 1));
`else
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shooter_d = shooter_q;
        live_d    = live_q;
        chamber_d = chamber_q;
        shots_d   = shots_q;
        cnt_d     = frame_tick ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            ST_MENU: if (rise_q[0]) begin
                state_d   = ST_IDLE;
                live_d    = draw_chamber(lfsr[2:0], CHAMBERS);
                chamber_d = '0;
                shots_d   = '0;
            end
            ST_IDLE: if (idle_done) state_d = ST_P1_TURN;
            ST_P1_TURN: if (rise_q[1] || timeout) begin
                state_d   = ST_FIRE;
                shooter_d = 1'b0;
            end
            ST_P2_TURN: if (rise_q[2] || timeout) begin
                state_d   = ST_FIRE;
                shooter_d = 1'b1;
            end
            ST_FIRE: begin
                if (chamber_q == live_q) begin
                    state_d = shooter_q ? ST_P2_DOWN : ST_P1_DOWN;
                end else begin
                    chamber_d = (chamber_q == 3'(CHAMBERS - 1)) ? 3'd0 : chamber_q + 3'd1;
                    shots_d   = (shots_q == 4'hF) ? shots_q : shots_q + 4'd1;
                    state_d   = ST_RECOIL;
                end
            end
            ST_RECOIL: if (recoil_done) state_d = shooter_q ? ST_P1_TURN : ST_P2_TURN;
            ST_P1_DOWN, ST_P2_DOWN: if (down_done) state_d = ST_MENU;
            default: state_d = ST_MENU;
        endcase

        // A tick on the entry cycle belongs to the state being left.
        if (state_d != state_q) cnt_d = '0;

        // FIRE and RECOIL keep showing the scene of the turn that fired.
        case (state_d)
            ST_MENU:    scene_d = SCENE_MENU;
            ST_IDLE:    scene_d = SCENE_IDLE;
            ST_P1_TURN: scene_d = SCENE_P1_TURN;
            ST_P2_TURN: scene_d = SCENE_P2_TURN;
            ST_P1_DOWN: scene_d = SCENE_P1_DOWN;
            ST_P2_DOWN: scene_d = SCENE_P2_DOWN;
            default:    scene_d = scene_q;
        endcase

        show_d  = (state_d == ST_P1_TURN) || (state_d == ST_P2_TURN) ||
                  (state_d == ST_FIRE)    || (state_d == ST_RECOIL);
        gun_y_d = (state_d == ST_RECOIL) ? 10'(RECOIL_PX) : 10'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_q    <= '0;
            rise_q    <= '0;
            state_q   <= ST_MENU;
            shooter_q <= 1'b0;
            live_q    <= '0;
            chamber_q <= '0;
            shots_q   <= '0;
            scene_q   <= SCENE_MENU;
            show_q    <= 1'b0;
            gun_y_q   <= '0;
            cnt_q     <= '0;
        end else begin
            prev_q    <= level;
            rise_q    <= level & ~prev_q;
            state_q   <= state_d;
            shooter_q <= shooter_d;
            live_q    <= live_d;
            chamber_q <= chamber_d;
            shots_q   <= shots_d;
            scene_q   <= scene_d;
            show_q    <= show_d;
            gun_y_q   <= gun_y_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cur_game_state = scene_q;
    assign show_gun       = show_q;
    assign gun_y_dis      = gun_y_q;
    assign chamber_idx    = chamber_q;
    assign shots_fired    = shots_q;

endmodule

// File: tb/tb_revolver_game_ctrl.sv
// Randomized scoreboard bench for revolver_game_ctrl: a game-level model predicts
// each visible output change; a monitor pops and compares on every change.
`timescale 1ns/1ps
module tb_revolver_game_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NCH  = 6;

    logic       Clk     = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start      = 1'b0;
    logic       trigger_p1 = 1'b0;
    logic       trigger_p2 = 1'b0;
    logic [3:0] cur_game_state;
    logic       show_gun;
    logic [9:0] gun_y_dis;
    logic [2:0] chamber_idx;
    logic [3:0] shots_fired;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_snap_q[$];
    int          exp_tick_q[$];
    string       exp_tag_q[$];

    int live, ch, shots, player;
    bit round_over;
    bit timeout_done = 1'b0;

    revolver_game_ctrl dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_tick     (frame_tick),
        .start          (start),
        .trigger_p1     (trigger_p1),
        .trigger_p2     (trigger_p2),
        .cur_game_state (cur_game_state),
        .show_gun       (show_gun),
        .gun_y_dis      (gun_y_dis),
        .chamber_idx    (chamber_idx),
        .shots_fired    (shots_fired)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic int draw(input logic [15:0] l);
        int r;
        r = int'(l & 16'h0007);
        return (r >= NCH) ? r - NCH : r;
    endfunction

    function automatic logic [21:0] mk(input logic [3:0] c, input logic g, input logic [9:0] y,
                                       input int c_idx, input int sh);
        return {c, g, y, 3'(c_idx), 4'(sh)};
    endfunction

    function automatic void push(input logic [21:0] s, input int tk, input string tag);
        exp_snap_q.push_back(s);
        exp_tick_q.push_back(tk);
        exp_tag_q.push_back(tag);
    endfunction

    // Reference LFSR; lfsr_pre is the value the DUT saw at the latest edge.
    logic [15:0] lfsr_m, lfsr_pre;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr_m <= SEED;
        end else begin
            lfsr_pre <= lfsr_m;
            lfsr_m   <= lfsr_next(lfsr_m);
        end
    end

    // Frame ticks: one-cycle pulses, period 2..4 cycles.
    initial begin
        forever begin
            repeat ($urandom_range(3, 1)) @(negedge Clk);
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
    end

    // Monitor: every visible output change pops one expectation.
    initial begin
        logic [21:0] prev, cur, want;
        int ticks, want_tk;
        logic tk;
        string tag;
        prev  = '0;
        ticks = 0;
        forever begin
            @(posedge Clk);
            tk = frame_tick;
            #1;
            cur = {cur_game_state, show_gun, gun_y_dis, chamber_idx, shots_fired};
            if (!Reset_n) begin
                prev  = cur;
                ticks = 0;
            end else begin
                if (tk) ticks++;
                if (cur != prev) begin
                    checks++;
                    if (exp_snap_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: outputs=%h, required=%h (no change)", cur, prev);
                    end else begin
                        want    = exp_snap_q.pop_front();
                        want_tk = exp_tick_q.pop_front();
                        tag     = exp_tag_q.pop_front();
                        if (cur !== want || (want_tk >= 0 && ticks != want_tk)) begin
                            errors++;
                            $display("FAIL %s: outputs=%h ticks=%0d, required outputs=%h ticks=%0d",
                                     tag, cur, ticks, want, want_tk);
                        end else begin
                            $display("ok   %s: outputs=%h ticks=%0d", tag, cur, ticks);
                        end
                    end
                    prev  = cur;
                    ticks = 0;
                end
            end
        end
    end

    task automatic check_out(input string tag, input logic [21:0] want);
        logic [21:0] got;
        got = {cur_game_state, show_gun, gun_y_dis, chamber_idx, shots_fired};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: outputs=%h, required=%h", tag, got, want);
        end else begin
            $display("ok   %s: outputs=%h", tag, got);
        end
    endtask

    task automatic wait_drain(input int budget, input string what);
        int n;
        n = 0;
        while (exp_snap_q.size() != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (exp_snap_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: pending=%0d after %0d cycles, required 0", what, exp_snap_q.size(), budget);
            exp_snap_q.delete();
            exp_tick_q.delete();
            exp_tag_q.delete();
        end
    endtask

    task automatic start_round(input int want_live);
        if (want_live >= 0) begin
            for (int i = 0; i < 400; i++) begin
                if (draw(lfsr_next(lfsr_m)) == want_live) break;
                @(negedge Clk);
            end
        end
        push(mk(4'h0, 1'b0, 10'd0, 0, 0), -1, "idle_entry");
        push(mk(4'h2, 1'b1, 10'd0, 0, 0), 120, "p1_open");
        start = 1'b1;
        @(posedge Clk); #1;
        check_out("start_lat1", mk(4'hF, 1'b0, 10'd0, ch, shots));
        @(posedge Clk); #1;
        check_out("start_lat2", mk(4'h0, 1'b0, 10'd0, 0, 0));
        live = draw(lfsr_pre);
        $display("round: live chamber %0d", live);
        ch = 0; shots = 0; player = 1; round_over = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        wait_drain(2000, "idle");
    endtask

    // mode: 0 own trigger, 1 both triggers together, 2 opposite pulse first, 3 no press
    task automatic take_turn(input int mode);
        logic [3:0] turn_code, other_code, down_code;
        turn_code  = (player == 1) ? 4'h2 : 4'h1;
        other_code = (player == 1) ? 4'h1 : 4'h2;
        down_code  = (player == 1) ? 4'h4 : 4'h5;
        if (mode == 2) begin
            if (player == 1) trigger_p2 = 1'b1; else trigger_p1 = 1'b1;
            @(negedge Clk);
            trigger_p1 = 1'b0;
            trigger_p2 = 1'b0;
            repeat (5) @(negedge Clk);
            check_out("ignored_trigger", mk(turn_code, 1'b1, 10'd0, ch, shots));
        end
        if (ch == live) begin
            push(mk(down_code, 1'b0, 10'd0, ch, shots), -1, "player_down");
            push(mk(4'hF, 1'b0, 10'd0, ch, shots), 180, "down_to_menu");
            round_over = 1'b1;
        end else begin
            ch    = (ch == NCH - 1) ? 0 : ch + 1;
            shots = (shots < 15) ? shots + 1 : 15;
            push(mk(turn_code, 1'b1, 10'd6, ch, shots), -1, "recoil");
            push(mk(other_code, 1'b1, 10'd0, ch, shots), 8, "next_turn");
        end
        if (mode != 3) begin
            if (player == 1 || mode == 1) trigger_p1 = 1'b1;
            if (player == 2 || mode == 1) trigger_p2 = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge Clk);
            trigger_p1 = 1'b0;
            trigger_p2 = 1'b0;
        end
        wait_drain((mode == 3) ? 4000 : 3000, "turn");
        if (!round_over) player = 3 - player;
    endtask

    task automatic play_round(input int want_live, input int first_mode, input bit random_rest);
        int mode;
        start_round(want_live);
        for (int t = 0; t < NCH + 1 && !round_over; t++) begin
            mode = (t == 0) ? first_mode : (random_rest ? int'($urandom_range(2, 0)) : 0);
`ifdef TURN_TIMEOUT_EN
            if (player == 2 && !timeout_done) begin
                mode = 3;
                timeout_done = 1'b1;
            end
`endif
            take_turn(mode);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at 5ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ch = 0; shots = 0; player = 1; live = 0; round_over = 1'b0;
        repeat (3) @(negedge Clk);
        check_out("reset_hold", mk(4'hF, 1'b0, 10'd0, 0, 0));
        Reset_n = 1'b1;
        @(negedge Clk);
        check_out("reset_release", mk(4'hF, 1'b0, 10'd0, 0, 0));
        repeat (5) @(negedge Clk);

        play_round(2, 2, 1'b0);
        play_round(4, 1, 1'b0);
        play_round(-1, int'($urandom_range(2, 0)), 1'b1);
        play_round(-1, int'($urandom_range(2, 0)), 1'b1);

        // Asynchronous reset while the gun is recoiling.
        start_round(5);
        ch = 1; shots = 1;
        push(mk(4'h2, 1'b1, 10'd6, 1, 1), -1, "recoil_pre_reset");
        trigger_p1 = 1'b1;
        @(negedge Clk);
        trigger_p1 = 1'b0;
        wait_drain(200, "recoil");
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1 check_out("async_reset", mk(4'hF, 1'b0, 10'd0, 0, 0));
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        ch = 0; shots = 0;
        @(negedge Clk);
        check_out("reset_release2", mk(4'hF, 1'b0, 10'd0, 0, 0));
        repeat (4) @(negedge Clk);

        play_round(-1, int'($urandom_range(2, 0)), 1'b1);

        repeat (20) @(negedge Clk);
        checks++;
        if (exp_snap_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: pending=%0d, required 0", exp_snap_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
